truth_table_sweeper: RTL and testbench

//   Self-sequencing sweep engine for small combinational blocks. Drives every

---
 rtl/truth_table_sweeper.sv | 123 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a small combinational block, captures its 1-bit
// response into a truth table and compares it with an expected table.
// Optional macro MISMATCH_LOG_EN adds a mismatch count and lowest differing index.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 y,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int TW = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] CMP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // With no settle time the engine samples a new vector every cycle.
    localparam logic [2:0]      NEXT_VEC = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [N_IN-1:0] VEC_MAX  = {N_IN{1'b1}};
    localparam logic [CW-1:0]   CNT_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    logic [2:0]    state;
    logic [CW-1:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_out    <= '0;
            table_out  <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= NEXT_VEC;
                        settle_cnt <= '0;
                        vec_out    <= '0;
                        table_out  <= '0;
                        pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    table_out[vec_out] <= y;
                    // The vector counter parks at its maximum rather than wrapping.
                    if (vec_out == VEC_MAX) begin
                        state <= CMP;
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= NEXT_VEC;
                    end
                end
                CMP: begin
                    pass  <= (table_out == exp_table);
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE) || (state == CMP);
    assign done = (state == DONE);

`ifdef MISMATCH_LOG_EN
    logic [TW-1:0]   diff;
    logic [N_IN:0]   pop;
    logic [N_IN-1:0] low_idx;

    // Scanning downward leaves the lowest differing index as the final write.
    always_comb begin
        diff    = table_out ^ exp_table;
        pop     = '0;
        low_idx = '0;
        for (int k = TW - 1; k >= 0; k--) begin
            if (diff[k]) begin
                pop     = pop + 1'b1;
                low_idx = N_IN'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
        end else if (state == IDLE && start) begin
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
        end else if (state == CMP) begin
            mismatch_cnt  <= pop;
            first_err_idx <= low_idx;
        end
    end
`else
    assign mismatch_cnt  = '0;
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a default instance and a zero-settle
// instance, with expected tables derived from a behavioural model of the swept function.
module tb_truth_table_sweeper;

    logic       clk;
    logic       reset;

    logic       start_a, y_a, busy_a, done_a, pass_a;
    logic [7:0] exp_a, table_a;
    logic [2:0] vec_a, idx_a;
    logic [3:0] cnt_a;

    logic       start_b, y_b, busy_b, done_b, pass_b;
    logic [7:0] exp_b, table_b;
    logic [2:0] vec_b, idx_b;
    logic [3:0] cnt_b;

    int mode_a;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [3:0] cnt;
        logic [2:0] idx;
    } exp_t;
    exp_t sb[$];

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .y(y_a), .exp_table(exp_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .table_out(table_a),
        .pass(pass_a), .mismatch_cnt(cnt_a), .first_err_idx(idx_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .y(y_b), .exp_table(exp_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .table_out(table_b),
        .pass(pass_b), .mismatch_cnt(cnt_b), .first_err_idx(idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: y = (~b&~c)|(a&~b) with a = MSB; mode 1: constant 1.
    function automatic logic model_y(input int m, input logic [2:0] v);
        if (m == 1) return 1'b1;
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign y_a = model_y(mode_a, vec_a);
    assign y_b = vec_b[0];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int sel);
        exp_t e;
        logic [7:0] d;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            e.tbl[i] = (sel == 1) ? v[0] : model_y(mode_a, v);
        end
        d = e.tbl ^ ((sel == 1) ? exp_b : exp_a);
        e.pass = (d == 8'h00);
`ifdef MISMATCH_LOG_EN
        e.cnt = 4'($countones(d));
        e.idx = 3'd0;
        for (int i = 7; i >= 0; i--) if (d[i]) e.idx = 3'(i);
`else
        e.cnt = 4'd0;
        e.idx = 3'd0;
`endif
        sb.push_back(e);
    endtask

    // Pulses (or holds) start, then observes `limit` cycles after the accepting edge.
    task automatic run_sweep(input int sel, input int limit, input int repulse_at, input bit hold,
                             output int first_done, output int last_done, output int n_done);
        exp_t e;
        first_done = 0;
        last_done  = 0;
        n_done     = 0;
        @(negedge clk);
        if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (sel == 1) start_b = hold; else start_a = hold || (k == repulse_at);
            if (k == 1 || (hold && k == 28)) begin
                check_output("busy_at_sweep_start", (sel == 1) ? busy_b : busy_a, 1);
                check_output("table_cleared", (sel == 1) ? table_b : table_a, 0);
                check_output("pass_cleared", (sel == 1) ? pass_b : pass_a, 0);
            end
            if ((sel == 1) ? done_b : done_a) begin
                n_done++;
                if (first_done == 0) first_done = k;
                last_done = k;
                check_output("busy_in_done", (sel == 1) ? busy_b : busy_a, 0);
                if (sb.size() == 0) begin
                    check_output("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("table_out", (sel == 1) ? table_b : table_a, e.tbl);
                    check_output("pass", (sel == 1) ? pass_b : pass_a, e.pass);
                    check_output("mismatch_cnt", (sel == 1) ? cnt_b : cnt_a, e.cnt);
                    check_output("first_err_idx", (sel == 1) ? idx_b : idx_a, e.idx);
                end
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int fd, ld, nd;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        exp_a   = 8'h31;
        exp_b   = 8'hAA;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_output("rst_vec", vec_a, 0);
        check_output("rst_busy", busy_a, 0);
        check_output("rst_done", done_a, 0);
        check_output("rst_table", table_a, 0);
        check_output("rst_pass", pass_a, 0);
        check_output("rst_cnt", cnt_a, 0);
        check_output("rst_idx", idx_a, 0);

        // Matching function: done at cycle 26.
        push_expect(0);
        run_sweep(0, 40, 0, 1'b0, fd, ld, nd);
        check_output("match_done_cycle", fd, 26);
        check_output("match_done_count", nd, 1);
        check_output("vec_held_at_max", vec_a, 7);

        // Single-bit mismatch against 8'h33.
        exp_a = 8'h33;
        push_expect(0);
        run_sweep(0, 40, 0, 1'b0, fd, ld, nd);
        check_output("mismatch_done_cycle", fd, 26);

        // Start re-pulsed mid-sweep is ignored.
        exp_a = 8'h31;
        push_expect(0);
        run_sweep(0, 40, 10, 1'b0, fd, ld, nd);
        check_output("repulse_done_cycle", fd, 26);
        check_output("repulse_done_count", nd, 1);

        // Reset at cycle 12 aborts the sweep.
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        check_output("pre_reset_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_busy", busy_a, 0);
        check_output("abort_vec", vec_a, 0);
        check_output("abort_table", table_a, 0);
        check_output("abort_pass", pass_a, 0);
        push_expect(0);
        run_sweep(0, 40, 0, 1'b0, fd, ld, nd);
        check_output("after_reset_done_cycle", fd, 26);

        // Start held high: back-to-back sweeps every 27 cycles.
        mode_a = 1;
        exp_a  = 8'hFF;
        push_expect(0);
        push_expect(0);
        run_sweep(0, 53, 0, 1'b1, fd, ld, nd);
        check_output("hold_first_done", fd, 26);
        check_output("hold_second_done", ld, 53);
        check_output("hold_done_count", nd, 2);

        // Zero settle time: done at cycle 10.
        push_expect(1);
        run_sweep(1, 20, 0, 1'b0, fd, ld, nd);
        check_output("nosettle_done_cycle", fd, 10);
        check_output("nosettle_done_count", nd, 1);

        check_output("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
